regfile_dbg_arb: RTL and testbench

REGFILE_DBG_ARB -- requirements
Module: regfile_dbg_arb

---
 rtl/regfile_dbg_arb.sv | 98 +++++++++
 tb/tb_regfile_dbg_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_dbg_arb.sv
// regfile_dbg_arb: shares one register-file read port between the pipeline
// decode stage and a debug requester. The pipeline normally has priority;
// a debug read is accepted when the pipeline is idle, answered one cycle
// later, and the arbiter then spends one cycle in RESP before it can grant
// again.
//
// Build option: define REGFILE_DBG_ARB_STARVE_EN to enable the starvation
// override. After STARVE_LIMIT denied cycles the debug requester takes the
// port and the pipeline is stalled for that one cycle. With the macro
// undefined the pipeline always wins and cpu_stall is tied low.
module regfile_dbg_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd_req,
    input  logic [4:0]  cpu_rd_addr,
    output logic        cpu_stall,
    input  logic        dbg_req_valid,
    input  logic [4:0]  dbg_req_addr,
    output logic        dbg_req_ready,
    output logic        dbg_rsp_valid,
    output logic [31:0] dbg_rsp_data,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data
);

    // Catch an out-of-range limit at elaboration time.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("regfile_dbg_arb: STARVE_LIMIT must be 1..15");
    end

    typedef enum logic {IDLE, RESP} state_t;

    state_t state, state_nxt;
    logic   grant;

`ifdef REGFILE_DBG_ARB_STARVE_EN
    logic [3:0] starve_cnt;
    logic       starve_hit;
    assign starve_hit = (starve_cnt == 4'(STARVE_LIMIT));
`endif

    // State register. Reset drops any pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Grant decision, port steering and next state. Grant is gated by reset
    // so the pipeline owns the port while reset is held.
    always_comb begin
        grant         = 1'b0;
        state_nxt     = state;
        dbg_req_ready = 1'b0;
        cpu_stall     = 1'b0;
        rf_rd_addr    = cpu_rd_addr;
        dbg_rsp_valid = (state == RESP);
`ifdef REGFILE_DBG_ARB_STARVE_EN
        grant = !reset && (state == IDLE) && dbg_req_valid &&
                (!cpu_rd_req || starve_hit);
`else
        grant = !reset && (state == IDLE) && dbg_req_valid && !cpu_rd_req;
`endif
        if (grant) begin
            rf_rd_addr    = dbg_req_addr;
            dbg_req_ready = 1'b1;
`ifdef REGFILE_DBG_ARB_STARVE_EN
            cpu_stall     = cpu_rd_req;
`endif
        end
        case (state)
            IDLE:    if (grant) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Response data is captured at acceptance and held until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      dbg_rsp_data <= 32'h0;
        else if (grant) dbg_rsp_data <= rf_rd_data;
    end

`ifdef REGFILE_DBG_ARB_STARVE_EN
    // Count cycles where debug is denied in favour of the pipeline, saturating
    // at the limit; hold in RESP or with no debug request, clear on grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= 4'd0;
        else if (grant)
            starve_cnt <= 4'd0;
        else if (state == IDLE && dbg_req_valid && cpu_rd_req && !starve_hit)
            starve_cnt <= starve_cnt + 4'd1;
    end
`endif

endmodule

// File: tb/tb_regfile_dbg_arb.sv
// Self-checking bench for regfile_dbg_arb. A behavioural model (a pending
// response flag, a count of denied debug cycles and the last captured word)
// predicts every output; directed sequences cover the worked examples,
// then a randomized phase exercises mixed traffic and register-file updates.
module tb_regfile_dbg_arb;

    localparam int LIMIT = 4;
`ifdef REGFILE_DBG_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd_req;
    logic [4:0]  cpu_rd_addr;
    logic        cpu_stall;
    logic        dbg_req_valid;
    logic [4:0]  dbg_req_addr;
    logic        dbg_req_ready;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_data;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;

    logic [31:0] rf_mem [32];
    assign rf_rd_data = rf_mem[rf_rd_addr];

    regfile_dbg_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_rd_req    (cpu_rd_req),
        .cpu_rd_addr   (cpu_rd_addr),
        .cpu_stall     (cpu_stall),
        .dbg_req_valid (dbg_req_valid),
        .dbg_req_addr  (dbg_req_addr),
        .dbg_req_ready (dbg_req_ready),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rsp_data  (dbg_rsp_data),
        .rf_rd_addr    (rf_rd_addr),
        .rf_rd_data    (rf_rd_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit          m_pend;    // response owed on the current cycle
    int          m_denied;  // debug cycles lost to the pipeline since last grant
    logic [31:0] m_data;
    bit          last_grant;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend   = 1'b0;
        m_denied = 0;
        m_data   = 32'h0;
    endtask

    // One arbitration cycle. Entered just after a rising edge; drives the
    // inputs, checks the combinational decision, then crosses the next edge
    // and checks the response side.
    task automatic cycle(input logic req, input logic [4:0] ca,
                         input logic dv, input logic [4:0] da);
        bit          g;
        logic [31:0] word;
        cpu_rd_req    = req;
        cpu_rd_addr   = ca;
        dbg_req_valid = dv;
        dbg_req_addr  = da;
        #1;
        // Debug wins if the port is free of a response and either the
        // pipeline is quiet or debug has been denied LIMIT times.
        g = !m_pend && dv && (!req || (STARVE_ON && m_denied >= LIMIT));
        chk("ready", dbg_req_ready, g);
        chk("stall", cpu_stall, g && req);
        chk("rf_addr", rf_rd_addr, g ? da : ca);
        word = rf_mem[da];
        @(posedge clk);
        #1;
        if (g) begin
            m_data   = word;
            m_denied = 0;
            m_pend   = 1'b1;
        end else begin
            if (!m_pend && dv && req && m_denied < LIMIT) m_denied++;
            m_pend = 1'b0;
        end
        chk("rsp_valid", dbg_rsp_valid, m_pend);
        chk("rsp_data", dbg_rsp_data, m_data);
        last_grant = g;
    endtask

    initial begin
        int first_grant;
        logic dv;
        logic [4:0] da;

        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        reset = 1'b1;
        cpu_rd_req = 1'b0; cpu_rd_addr = 5'd9;
        dbg_req_valid = 1'b1; dbg_req_addr = 5'd3;
        model_reset();
        last_grant = 1'b0;

        // Reset state: debug request present but must not be granted.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", dbg_rsp_valid, 1'b0);
        chk("rst_rsp_data", dbg_rsp_data, 32'h0);
        chk("rst_ready", dbg_req_ready, 1'b0);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_rf_addr", rf_rd_addr, 5'd9);
        reset = 1'b0;
        dbg_req_valid = 1'b0;

        // Idle pipeline read of a known word, one-cycle latency.
        rf_mem[5] = 32'hDEADBEEF;
        cycle(1'b0, 5'd1, 1'b1, 5'd5);
        chk("deadbeef", dbg_rsp_data, 32'hDEADBEEF);
        cycle(1'b0, 5'd1, 1'b0, 5'd0);

        // Pipeline holds the port continuously: starvation override or not.
        first_grant = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 5'd7, 1'b1, 5'd12);
            if (last_grant && first_grant < 0) first_grant = i;
            if (last_grant) break;
        end
        chk("starve_grant_cycle", 32'(first_grant), STARVE_ON ? 32'(LIMIT) : 32'hFFFF_FFFF);
        cycle(1'b0, 5'd7, 1'b0, 5'd0);
        cycle(1'b0, 5'd7, 1'b0, 5'd0);

        // Back-to-back debug with pipeline idle: grant every second cycle.
        for (int i = 0; i < 6; i++) cycle(1'b0, 5'd2, 1'b1, 5'(i + 20));
        cycle(1'b0, 5'd2, 1'b0, 5'd0);

        // Three denials, then grant with pipeline idle; count must restart.
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd4, 1'b1, 5'd17);
        cycle(1'b0, 5'd4, 1'b1, 5'd17);
        chk("grant_after_3", last_grant, 1'b1);
        cycle(1'b0, 5'd4, 1'b0, 5'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'd6, 1'b1, 5'd18);
        cycle(1'b0, 5'd6, 1'b0, 5'd0);
        cycle(1'b0, 5'd6, 1'b0, 5'd0);

        // Reset landing in RESP kills the response at once and for good.
        cycle(1'b0, 5'd8, 1'b1, 5'd30);
        chk("pre_rst_rsp", dbg_rsp_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", dbg_rsp_valid, 1'b0);
        chk("midrst_rsp_data", dbg_rsp_data, 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd8, 1'b0, 5'd0);

        // Randomized traffic; a denied debug request keeps its address.
        dv = 1'b0; da = 5'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rf_mem[$urandom_range(0, 31)] = $urandom;
            if (!(dv && !last_grant)) begin
                dv = ($urandom_range(0, 2) != 0);
                da = 5'($urandom);
            end
            cycle(($urandom_range(0, 3) != 0), 5'($urandom), dv, da);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
